// File: rtl/fp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mac_sequencer
//  Purpose  : Requester-side controller for a TAPS-long floating-point dot
//             product, result = sum(coef[k] * sample[k]). Walks the tap
//             store, issues one multiply and one accumulate per tap through
//             the shared fp wrappers' en/done handshake and reports the
//             final IEEE-754 single-precision sum.
//  Ports    : i_clk, i_rst          clock, synchronous active-high reset
//             i_start               run request (sampled only in IDLE)
//             o_busy/o_done/o_error run status, done pulse, timeout flag
//             o_result              last successfully completed sum
//             o_rd_addr             tap index to store; i_coef/i_sample
//                                   return data one cycle later
//             o_mul_en/a/b, i_mul_result/i_mul_done   multiplier handshake
//             o_add_en/a/b, i_add_result/i_add_done   adder handshake
//  Revision : 1.0  initial release
// ============================================================================
module fp_mac_sequencer #(
    parameter int TAPS    = 8,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [31:0]       o_result,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [31:0]       i_coef,
    input  logic [31:0]       i_sample,
    output logic              o_mul_en,
    output logic [31:0]       o_mul_a,
    output logic [31:0]       o_mul_b,
    input  logic [31:0]       i_mul_result,
    input  logic              i_mul_done,
    output logic              o_add_en,
    output logic [31:0]       o_add_a,
    output logic [31:0]       o_add_b,
    input  logic [31:0]       i_add_result,
    input  logic              i_add_done
);

    localparam int              c_WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_ONE     = c_WAIT_W'(1);
    localparam logic [ADDR_W-1:0]   c_LAST    = ADDR_W'(TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LATCH    = 3'd2,
        S_MUL_REQ  = 3'd3,
        S_MUL_WAIT = 3'd4,
        S_ADD_REQ  = 3'd5,
        S_ADD_WAIT = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_mul_en;
    logic                w_add_en;
    logic                w_expired;

    logic [ADDR_W-1:0]   r_k;
    logic [c_WAIT_W-1:0] r_wait;
    logic [31:0]         r_acc;
    logic [31:0]         r_result;
    logic [31:0]         r_mul_a;
    logic [31:0]         r_mul_b;
    logic [31:0]         r_add_b;
    logic                r_done;
    logic                r_error;

    // r_wait holds the index (1-based) of the current wait cycle, so the
    // last permitted cycle is the one where it equals TIMEOUT.
    assign w_expired = (r_wait == c_TIMEOUT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and request strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_mul_en = 1'b0;
        w_add_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH:   w_next = S_LATCH;
            S_LATCH:   w_next = S_MUL_REQ;
            S_MUL_REQ: begin
                w_mul_en = 1'b1;
                w_next   = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                // A done in the final permitted cycle still wins.
                if (i_mul_done) begin
                    w_next = S_ADD_REQ;
                end else if (w_expired) begin
                    w_next = S_IDLE;
                end
            end
            S_ADD_REQ: begin
                w_add_en = 1'b1;
                w_next   = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (i_add_done) begin
                    w_next = (r_k == c_LAST) ? S_IDLE : S_FETCH;
                end else if (w_expired) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_k      <= '0;
            r_wait   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_add_b  <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_error <= 1'b0;
                    end
                end
                S_LATCH: begin
                    // Store data is valid now, one cycle after rd_addr.
                    r_mul_a <= i_coef;
                    r_mul_b <= i_sample;
                end
                S_MUL_REQ: begin
                    r_wait <= c_ONE;
                end
                S_MUL_WAIT: begin
                    if (i_mul_done) begin
                        r_add_b <= i_mul_result;
                    end else if (w_expired) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + c_ONE;
                    end
                end
                S_ADD_REQ: begin
                    r_wait <= c_ONE;
                end
                S_ADD_WAIT: begin
                    if (i_add_done) begin
                        r_acc <= i_add_result;
                        if (r_k == c_LAST) begin
                            r_result <= i_add_result;
                            r_done   <= 1'b1;
                        end else begin
                            r_k <= r_k + ADDR_W'(1);
                        end
                    end else if (w_expired) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + c_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. add_a follows the accumulator directly: acc only changes
    // after the add_done cycle, so it is stable across each add request.
    // ------------------------------------------------------------------
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_error   = r_error;
    assign o_result  = r_result;
    assign o_rd_addr = r_k;
    assign o_mul_en  = w_mul_en;
    assign o_mul_a   = r_mul_a;
    assign o_mul_b   = r_mul_b;
    assign o_add_en  = w_add_en;
    assign o_add_a   = r_acc;
    assign o_add_b   = r_add_b;

endmodule
`default_nettype wire

// File: doc/fp_mac_sequencer.md
# fp_mac_sequencer

Requester-side controller that computes a TAPS-long floating-point dot product, result = Σ coef[k]·sample[k], by driving the shared fp multiplier and fp adder wrappers through their clk_en/done handshake. It reads operand pairs from a coefficient/sample store, issues one multiply and one accumulate per tap, and reports a single 32-bit IEEE-754 result. It sits between the effect-chain control logic and the floating_arithmetics wrappers, and it is the initiator for the protocol those wrappers respond to.

## Interface
- TAPS, 8: number of products accumulated per run (≥1).
- ADDR_W, 3: width of rd_addr; 2^ADDR_W ≥ TAPS.
- TIMEOUT, 15: maximum number of wait cycles allowed for any single done before the run aborts.

- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run (normal or aborted).
- error  out  1  set on timeout abort; cleared when the next start is accepted.
- result  out  32  accumulated sum; updated only on normal completion; held otherwise.
- rd_addr  out  ADDR_W  tap index presented to the store.
- coef, sample  in  32 each  store read data; valid the cycle after rd_addr.
- mul_en  out  1  one-cycle multiply request pulse.
- mul_a, mul_b  out  32 each  multiply operands.
- mul_result  in  32  product; valid in the mul_done cycle.
- mul_done  in  1  multiply completion pulse.
- add_en  out  1  one-cycle add request pulse.
- add_a, add_b  out  32 each  add operands.
- add_result  in  32  sum; valid in the add_done cycle.
- add_done  in  1  add completion pulse.

## Operation
- States: IDLE, FETCH, LATCH, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT.
- IDLE: if start is high, go to FETCH with k=0, acc=0x00000000, and error=0.
- FETCH: rd_addr=k. Next state is LATCH.
- LATCH: register coef→mul_a and sample→mul_b. Next state is MUL_REQ.
- MUL_REQ: mul_en=1 for exactly this cycle. Next state is MUL_WAIT with the wait counter cleared.
- MUL_WAIT: on mul_done, capture mul_result into add_b and go to ADD_REQ.
- ADD_REQ: add_a=acc and add_en=1 for exactly this cycle. Next state is ADD_WAIT with the wait counter cleared.
- ADD_WAIT: on add_done, acc←add_result.
  - If k==TAPS-1, go to IDLE, result←add_result, and pulse done.
  - Otherwise k←k+1 and go to FETCH.
- Operand hold: mul_a/mul_b stay constant from MUL_REQ through the mul_done cycle. add_a/add_b stay constant from ADD_REQ through the add_done cycle.
- Only one request is outstanding at any time. No en is asserted while waiting.
- Wait counter: counts cycles spent in a WAIT state, starting at 1 in the first wait cycle.
  - If it reaches TIMEOUT and done is not high in that cycle: go to IDLE, set error=1, pulse done, keep result unchanged.
  - A done arriving in the TIMEOUT-th cycle counts as success.
- mul_done/add_done arriving outside the matching WAIT state are ignored.
- start while busy is ignored. start in the cycle done pulses is accepted, because the block is in IDLE.
- Accumulation is always acc+product, including tap 0 (acc starts at +0.0). No width changes: all data paths are 32-bit pass-through.

## Timing
- Reset values: state=IDLE, busy=0, done=0, error=0, result=0, mul_en=0, add_en=0, rd_addr=0, all operand outputs=0, acc=0, k=0.
- Reset mid-run: the block is in IDLE the next cycle, with no en asserted and no done pulse. Any late done pulses are ignored.
- Let start be sampled high in IDLE at cycle s. Then FETCH(tap 0) is at s+1.
- Per tap, with FETCH at f:
  - LATCH at f+1, mul_en at f+2.
  - mul_done at f+2+Lm, where Lm≥1.
  - add_en at f+3+Lm, add_done at f+3+Lm+La.
  - Next FETCH at f+4+Lm+La.
- Total run: done and busy=0 at s+1+TAPS·(4+Lm+La). result is valid from that cycle.
- busy=1 from s+1 through the cycle before done. In the done cycle, busy=0.

## Test plan
- TAPS=4, Lm=6, La=7, coef=1.0 (0x3F800000), sample=0.5 (0x3F000000), start at cycle 0 → mul_en at cycles 3/20/37/54; done at cycle 69; result=0x40000000; error=0.
- Operand hold: corrupt coef/sample while in MUL_WAIT → mul_a/mul_b unchanged until mul_done; add_a/add_b unchanged through add_done.
- Multiplier never answers, TIMEOUT=15 → mul_en at 3; done=1 and error=1 at cycle 19; result keeps its previous value; the next start clears error.
- mul_done in exactly the 15th wait cycle → treated as success and the run completes normally. Stray add_done during MUL_WAIT → ignored.
- Assert start throughout a run → exactly one run. Start held high in the done cycle → a second run begins the next cycle with acc reset to 0.
- Reset asserted at cycle 30 mid-run → at 31: busy=0, mul_en=add_en=0, done=0, result=0. Later done pulses from the wrappers cause no state change.
